// File: rtl/map_090_irq.sv
// JY Company IRQ timer: prescaler + counter that count one of four event
// sources up or down, raising a sticky IRQ when the counter wraps.
module map_090_irq #(
    parameter bit          XOR_EN    = 1'b1,
    parameter int unsigned PRE_SHORT = 3
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       reg_we,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_dat,
    input  logic       ev_m2,
    input  logic       ev_a12,
    input  logic       ev_ppurd,
    input  logic       ev_cpuwr,
    output logic       irq,
    output logic [7:0] pre_out,
    output logic [7:0] cnt_out
);

    typedef enum logic [2:0] {
        REG_EN    = 3'd0,
        REG_MODE  = 3'd1,
        REG_DIS   = 3'd2,
        REG_ENA   = 3'd3,
        REG_PRE   = 3'd4,
        REG_CNT   = 3'd5,
        REG_XOR   = 3'd6,
        REG_NONE  = 3'd7
    } reg_sel_e;

    logic [7:0] pre_q, pre_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] xr_q, xr_d;
    logic       irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    reg_sel_e               reg_sel;
    logic                   src_ev;
    logic                   dir_up;
    logic                   dir_dn;
    logic                   step_en;
    logic                   pre_carry;
    logic                   cnt_carry;
    logic                   terminal;
    logic                   irq_clr;
    logic [7:0]             pre_stepped;
    logic [PRE_SHORT-1:0]   short_f;
    logic [PRE_SHORT-1:0]   short_step;

    assign reg_sel = reg_sel_e'(reg_addr);

    // Event selection, prescaler/counter stepping and carry detection
    always_comb begin
        src_ev      = 1'b0;
        dir_up      = (mode_q[7:6] == 2'b01);
        dir_dn      = (mode_q[7:6] == 2'b10);
        short_f     = pre_q[PRE_SHORT-1:0];
        short_step  = dir_up ? short_f + 1'b1 : short_f - 1'b1;
        pre_stepped = pre_q;
        pre_carry   = 1'b0;
        case (mode_q[1:0])
            2'd0:    src_ev = ev_m2;
            2'd1:    src_ev = ev_a12;
            2'd2:    src_ev = ev_ppurd;
            default: src_ev = ev_cpuwr;
        endcase
        // A prescaler write overrides the step entirely, including its carry
        step_en = src_ev && (dir_up || dir_dn) && !(reg_we && reg_sel == REG_PRE);
        if (mode_q[2]) begin
            pre_stepped = {pre_q[7:PRE_SHORT], short_step};
            pre_carry   = dir_up ? (&short_f) : ~(|short_f);
        end else begin
            pre_stepped = dir_up ? pre_q + 8'd1 : pre_q - 8'd1;
            pre_carry   = dir_up ? (&pre_q) : ~(|pre_q);
        end
        // A counter write drops any carry arriving in the same cycle
        cnt_carry = step_en && pre_carry && !(reg_we && reg_sel == REG_CNT);
        terminal  = cnt_carry && (dir_up ? (cnt_q == 8'hFF) : (cnt_q == 8'h00));
    end

    // Next-state for all registers: stepping first, CPU writes override
    always_comb begin
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        xr_d     = xr_q;
        irq_en_d = irq_en_q;
        irq_d    = irq_q;
        irq_clr  = 1'b0;
        if (step_en) begin
            pre_d = pre_stepped;
        end
        if (cnt_carry) begin
            cnt_d = dir_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
        end
        if (reg_we) begin
            case (reg_sel)
                REG_EN: begin
                    irq_en_d = reg_dat[0];
                    irq_clr  = ~reg_dat[0];
                end
                REG_MODE: mode_d = reg_dat;
                REG_DIS: begin
                    irq_en_d = 1'b0;
                    irq_clr  = 1'b1;
                end
                REG_ENA:  irq_en_d = 1'b1;
                REG_PRE:  pre_d = reg_dat ^ xr_q;
                REG_CNT:  cnt_d = reg_dat ^ xr_q;
                REG_XOR:  xr_d  = XOR_EN ? reg_dat : '0;
                default:  ;
            endcase
        end
        // Terminal sets against the post-write enable; an explicit clear wins
        if (terminal && irq_en_d) begin
            irq_d = 1'b1;
        end
        if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (map_rst) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            xr_q     <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            xr_q     <= xr_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign pre_out = pre_q;
    assign cnt_out = cnt_q;

endmodule
